// File: rtl/bus_slave_memory.sv
// rtl/bus_slave_memory.sv - DMA bus responder with windowed local word memory and a local access port
// Bus outputs are forced to 0 outside the states that own them so they can be wired-OR onto a shared bus.
module bus_slave_memory #(
  parameter logic [31:0] Base      = 32'h40000000,
  parameter int          AddrWidth = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          address_dataIN,
  input  logic [3:0]           byte_enableIN,
  input  logic [7:0]           burst_sizeIN,
  input  logic                 read_n_writeIN,
  input  logic                 begin_transactionIN,
  input  logic                 end_transactionIN,
  input  logic                 data_validIN,
  input  logic                 busyIN,
  output logic [31:0]          address_dataOUT,
  output logic                 end_transactionOUT,
  output logic                 data_validOUT,
  output logic                 busyOUT,
  output logic                 errorOUT,
  input  logic [AddrWidth-1:0] local_address,
  input  logic                 local_writeEnable,
  input  logic [31:0]          local_dataIn,
  output logic [31:0]          local_dataOut
);

  localparam int Depth = 1 << AddrWidth;

  typedef enum logic [2:0] {
    S_IDLE, S_ERROR, S_WRITE, S_READ_FETCH, S_READ_DATA, S_READ_END
  } state_t;

  state_t               r_state, w_next_state;
  logic [31:0]          r_mem [Depth];
  logic [AddrWidth-1:0] r_index;
  logic [AddrWidth-1:0] w_rd_index;
  logic [3:0]           r_be;
  logic [8:0]           r_remaining;
  logic [31:0]          r_rdata;
  logic [31:0]          w_be_mask;
  logic                 w_begin, w_hit, w_bus_wr, w_overflow, w_rd_advance, w_rd_en;

  assign w_begin    = (r_state == S_IDLE) && begin_transactionIN;
  assign w_hit      = (address_dataIN[31:AddrWidth+2] == Base[31:AddrWidth+2]);
  // Bit 8 of the remaining count sets once burst_size+1 words have been taken.
  assign w_overflow = (r_state == S_WRITE) && data_validIN && !local_writeEnable && r_remaining[8];
  assign w_bus_wr   = (r_state == S_WRITE) && data_validIN && !local_writeEnable && !r_remaining[8];
  assign w_rd_advance = (r_state == S_READ_DATA) && !busyIN && !end_transactionIN;
  // Prefetch the next word while the current one is being accepted, so bursts run without bubbles.
  assign w_rd_en    = (r_state == S_READ_FETCH) || ((r_state == S_READ_DATA) && !busyIN);
  assign w_rd_index = (r_state == S_READ_DATA) ? r_index + AddrWidth'(1) : r_index;
  assign w_be_mask  = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (begin_transactionIN) begin
          if (!w_hit)              w_next_state = S_ERROR;
          else if (read_n_writeIN) w_next_state = S_READ_FETCH;
          else                     w_next_state = S_WRITE;
        end
      end
      S_ERROR: w_next_state = S_IDLE;
      S_WRITE: begin
        if (w_overflow)             w_next_state = S_ERROR;
        else if (end_transactionIN) w_next_state = S_IDLE;
      end
      S_READ_FETCH: w_next_state = end_transactionIN ? S_IDLE : S_READ_DATA;
      S_READ_DATA: begin
        if (end_transactionIN)                         w_next_state = S_IDLE;
        else if (!busyIN && (r_remaining == 9'd0))     w_next_state = S_READ_END;
      end
      S_READ_END: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    address_dataOUT    = '0;
    data_validOUT      = 1'b0;
    end_transactionOUT = 1'b0;
    busyOUT            = 1'b0;
    errorOUT           = 1'b0;
    case (r_state)
      S_ERROR:  errorOUT = 1'b1;
      S_WRITE:  busyOUT  = data_validIN && local_writeEnable;
      S_READ_DATA: begin
        data_validOUT   = 1'b1;
        address_dataOUT = r_rdata & w_be_mask;
      end
      S_READ_END: end_transactionOUT = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_index     <= '0;
      r_be        <= '0;
      r_remaining <= '0;
    end else if (w_begin) begin
      r_index     <= address_dataIN[AddrWidth+1:2];
      r_be        <= byte_enableIN;
      r_remaining <= {1'b0, burst_sizeIN};
    end else if (w_bus_wr || w_rd_advance) begin
      r_index     <= r_index + AddrWidth'(1);
      r_remaining <= r_remaining - 9'd1;
    end
  end

  // Local writes always win; a colliding bus word is refused via busyOUT and retried.
  always_ff @(posedge clock) begin
    if (local_writeEnable) begin
      r_mem[local_address] <= local_dataIn;
    end else if (w_bus_wr) begin
      if (r_be[0]) r_mem[r_index][7:0]   <= address_dataIN[7:0];
      if (r_be[1]) r_mem[r_index][15:8]  <= address_dataIN[15:8];
      if (r_be[2]) r_mem[r_index][23:16] <= address_dataIN[23:16];
      if (r_be[3]) r_mem[r_index][31:24] <= address_dataIN[31:24];
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_index];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      local_dataOut <= '0;
    end else begin
      local_dataOut <= r_mem[local_address];
    end
  end

endmodule
